// File: rtl/config_pkg.sv
// config_pkg: minimal core configuration for the trace buffer.
// Exposes only the field this block reads (NrCommitPorts).
package config_pkg;
  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};
endpackage

// File: rtl/rvfi_trace_pkg.sv
// rvfi_trace_pkg: shared constants and trace-record typedef helper.
// The RVFI_TRACE_REC_T macro builds the head-record struct from an RVFI type and a port width.
// With RVFI_TRACE_ORDER_EN defined, the record gains a 64-bit order field.
package rvfi_trace_pkg;
  localparam int unsigned DropCntW = 16;
  localparam int unsigned OrderW = 64;
  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
  } rvfi_instr_min_t;
  function automatic int unsigned port_w(int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage
`ifndef RVFI_TRACE_REC_T
`ifdef RVFI_TRACE_ORDER_EN
`define RVFI_TRACE_REC_T(RVFI_T, PORT_W) struct packed { logic [rvfi_trace_pkg::OrderW-1:0] order; logic [(PORT_W)-1:0] port; RVFI_T rvfi; }
`else
`define RVFI_TRACE_REC_T(RVFI_T, PORT_W) struct packed { logic [(PORT_W)-1:0] port; RVFI_T rvfi; }
`endif
`endif

// File: rtl/rvfi_trace_compactor.sv
// rvfi_trace_compactor: packs valid commit ports into slots, lowest port first.
// Ports: valid_i (per-port valid), k_o (number of valid ports), slot_port_o (source port per slot).
module rvfi_trace_compactor #(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned PortW   = 1,
  parameter int unsigned KW      = 2
) (
  input  logic [NrPorts-1:0]            valid_i,
  output logic [KW-1:0]                 k_o,
  output logic [NrPorts-1:0][PortW-1:0] slot_port_o
);
  always_comb begin
    int unsigned cnt;
    cnt = 0;
    slot_port_o = '0;
    for (int i = 0; i < NrPorts; i++) begin
      if (valid_i[i]) begin
        slot_port_o[cnt] = PortW'(i);
        cnt = cnt + 1;
      end
    end
    k_o = KW'(cnt);
  end
endmodule

// File: rtl/cva6_rvfi_trace_buffer.sv
// cva6_rvfi_trace_buffer: compacts RVFI commit records into a FIFO drained one per cycle.
// Ports: clk_i/rst_ni (async active-low), rvfi_instr_i (commit records, port 0 oldest),
// clear_i (sync flush), trace_valid_o/trace_ready_i/trace_o (head stream),
// overflow_o (sticky drop flag), drop_cnt_o (saturating drop count), level_o (occupancy).
// Optional RVFI_TRACE_ORDER_EN adds a per-record order stamp counting accepted and dropped records.
module cva6_rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type rvfi_instr_t = rvfi_instr_min_t,
  parameter int unsigned Depth = 16,
  parameter type trace_rec_t = `RVFI_TRACE_REC_T(rvfi_instr_t, port_w(CVA6Cfg.NrCommitPorts)),
  localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts,
  localparam int unsigned PortW = port_w(CVA6Cfg.NrCommitPorts),
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LevelW = $clog2(Depth) + 1,
  localparam int unsigned KW = $clog2(CVA6Cfg.NrCommitPorts + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  rvfi_instr_t [NrPorts-1:0]        rvfi_instr_i,
  input  logic                             clear_i,
  output logic                             trace_valid_o,
  input  logic                             trace_ready_i,
  output trace_rec_t                       trace_o,
  output logic                             overflow_o,
  output logic [DropCntW-1:0]              drop_cnt_o,
  output logic [LevelW-1:0]                level_o
);
  logic [NrPorts-1:0]            valid;
  logic [KW-1:0]                 k;
  logic [NrPorts-1:0][PortW-1:0] slot_port;
  trace_rec_t                    mem_q [Depth];
  trace_rec_t                    mem_d [Depth];
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]             level_q, level_d, free;
  logic                          overflow_q, overflow_d;
  logic [DropCntW-1:0]           drop_cnt_q, drop_cnt_d;
  logic [DropCntW:0]             drop_sum;
  logic                          fits, push, pop, drop;
`ifdef RVFI_TRACE_ORDER_EN
  logic [OrderW-1:0]             order_q, order_d;
`endif
  always_comb begin
    valid = '0;
    for (int i = 0; i < NrPorts; i++) valid[i] = rvfi_instr_i[i].valid;
  end
  rvfi_trace_compactor #(
    .NrPorts(NrPorts),
    .PortW  (PortW),
    .KW     (KW)
  ) u_compactor (
    .valid_i    (valid),
    .k_o        (k),
    .slot_port_o(slot_port)
  );
  assign trace_valid_o = level_q != '0;
  assign trace_o       = mem_q[rd_ptr_q];
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign level_o       = level_q;
  always_comb begin
    trace_rec_t rec;
    rec = '0;
    // free space is taken before any same-cycle pop, so a pop never makes room for a push
    free = LevelW'(Depth) - level_q;
    fits = LevelW'(k) <= free;
    push = !clear_i && k != '0 && fits;
    drop = !clear_i && !fits;
    pop  = !clear_i && trace_valid_o && trace_ready_i;
    mem_d = mem_q;
    for (int s = 0; s < NrPorts; s++) begin
      rec.port = slot_port[s];
      rec.rvfi = rvfi_instr_i[slot_port[s]];
`ifdef RVFI_TRACE_ORDER_EN
      rec.order = order_q + OrderW'(s);
`endif
      if (push && KW'(s) < k) mem_d[wr_ptr_q + PtrW'(s)] = rec;
    end
    wr_ptr_d   = clear_i ? '0 : wr_ptr_q + (push ? PtrW'(k) : '0);
    rd_ptr_d   = clear_i ? '0 : rd_ptr_q + PtrW'(pop);
    level_d    = clear_i ? '0 : level_q + (push ? LevelW'(k) : '0) - LevelW'(pop);
    drop_sum   = {1'b0, drop_cnt_q} + (DropCntW + 1)'(k);
    drop_cnt_d = clear_i ? '0 : !drop ? drop_cnt_q : drop_sum[DropCntW] ? '1 : drop_sum[DropCntW-1:0];
    overflow_d = !clear_i && (overflow_q || drop);
`ifdef RVFI_TRACE_ORDER_EN
    // every incoming record consumes an order number, dropped ones included
    order_d = clear_i ? '0 : order_q + OrderW'(k);
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef RVFI_TRACE_ORDER_EN
      order_q    <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef RVFI_TRACE_ORDER_EN
      order_q    <= order_d;
`endif
    end
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule

// File: tb/tb_cva6_rvfi_trace_buffer.sv
// tb_cva6_rvfi_trace_buffer: directed self-checking bench for cva6_rvfi_trace_buffer.
module tb_cva6_rvfi_trace_buffer;
  localparam config_pkg::cva6_cfg_t Cfg = '{NrCommitPorts: 2};
  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
  } rvfi_t;
`ifdef RVFI_TRACE_ORDER_EN
  typedef struct packed {
    logic [63:0] order;
    logic [0:0]  port;
    rvfi_t       rvfi;
  } rec_t;
`else
  typedef struct packed {
    logic [0:0] port;
    rvfi_t      rvfi;
  } rec_t;
`endif
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  rvfi_t [1:0] instr;
  rec_t        trace;
  logic        tvalid, ovf;
  logic [15:0] drop;
  logic [4:0]  level;
  int          checks = 0;
  int          errors = 0;
  cva6_rvfi_trace_buffer #(
    .CVA6Cfg     (Cfg),
    .rvfi_instr_t(rvfi_t),
    .Depth       (16),
    .trace_rec_t (rec_t)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rvfi_instr_i (instr),
    .clear_i      (clear),
    .trace_valid_o(tvalid),
    .trace_ready_i(ready),
    .trace_o      (trace),
    .overflow_o   (ovf),
    .drop_cnt_o   (drop),
    .level_o      (level)
  );
`ifdef RVFI_TRACE_ORDER_EN
  logic        ready4 = 1'b0;
  rvfi_t [1:0] instr4;
  rec_t        trace4;
  logic        tvalid4, ovf4;
  logic [15:0] drop4;
  logic [2:0]  level4;
  cva6_rvfi_trace_buffer #(
    .CVA6Cfg     (Cfg),
    .rvfi_instr_t(rvfi_t),
    .Depth       (4),
    .trace_rec_t (rec_t)
  ) u_dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rvfi_instr_i (instr4),
    .clear_i      (1'b0),
    .trace_valid_o(tvalid4),
    .trace_ready_i(ready4),
    .trace_o      (trace4),
    .overflow_o   (ovf4),
    .drop_cnt_o   (drop4),
    .level_o      (level4)
  );
`endif
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v0, input logic [31:0] i0, input logic v1, input logic [31:0] i1);
    instr[0] = '{valid: v0, insn: i0};
    instr[1] = '{valid: v1, insn: i1};
  endtask
  initial begin
    instr = '0;
`ifdef RVFI_TRACE_ORDER_EN
    instr4 = '0;
`endif
    repeat (2) tick();
    chk("rst_valid", tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    rst_ni = 1'b1;
    tick();
    // single port streaming at full rate
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100 + i, 0, 0);
      tick();
      chk("sp_valid", tvalid, 1);
      chk("sp_insn", trace.rvfi.insn, 64'h100 + i);
      chk("sp_port", trace.port, 0);
      chk("sp_level", level, 1);
    end
    drive(0, 0, 0, 0);
    tick();
    chk("sp_drain_level", level, 0);
    chk("sp_drain_valid", tvalid, 0);
    // compaction: port 1 alone, then both ports
    ready = 1'b0;
    drive(0, 0, 1, 32'h200);
    tick();
    drive(1, 32'h201, 1, 32'h202);
    tick();
    drive(0, 0, 0, 0);
    chk("cmp_level", level, 3);
    chk("cmp_x_insn", trace.rvfi.insn, 'h200);
    chk("cmp_x_port", trace.port, 1);
    ready = 1'b1;
    tick();
    chk("cmp_a_insn", trace.rvfi.insn, 'h201);
    chk("cmp_a_port", trace.port, 0);
    tick();
    chk("cmp_b_insn", trace.rvfi.insn, 'h202);
    chk("cmp_b_port", trace.port, 1);
    tick();
    chk("cmp_empty", level, 0);
    // fill to full, then overflow with two records
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h300 + 2 * i, 1, 32'h301 + 2 * i);
      tick();
    end
    chk("full_level", level, 16);
    chk("full_ovf", ovf, 0);
    chk("full_drop", drop, 0);
    drive(1, 32'h3f0, 1, 32'h3f1);
    tick();
    drive(0, 0, 0, 0);
    chk("ovf_level", level, 16);
    chk("ovf_drop", drop, 2);
    chk("ovf_flag", ovf, 1);
    chk("ovf_head", trace.rvfi.insn, 'h300);
    // push and pop while full: push is still dropped
    ready = 1'b1;
    drive(1, 32'h3f2, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    ready = 1'b0;
    chk("pp_drop", drop, 3);
    chk("pp_level", level, 15);
    chk("pp_head", trace.rvfi.insn, 'h301);
    chk("pp_port", trace.port, 1);
    ready = 1'b1;
    repeat (8) tick();
    ready = 1'b0;
    chk("pop8_level", level, 7);
    chk("pop8_head", trace.rvfi.insn, 'h309);
    chk("pop8_ovf", ovf, 1);
    // clear beats concurrent pushes
    clear = 1'b1;
    drive(1, 32'h500, 1, 32'h501);
    tick();
    clear = 1'b0;
    drive(0, 0, 0, 0);
    chk("clr_level", level, 0);
    chk("clr_valid", tvalid, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_drop", drop, 0);
    tick();
    chk("clr_after_level", level, 0);
    drive(0, 0, 1, 32'h600);
    tick();
    drive(0, 0, 0, 0);
    chk("post_clr_level", level, 1);
    chk("post_clr_head", trace.rvfi.insn, 'h600);
    chk("post_clr_port", trace.port, 1);
    drive(1, 32'h601, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("pre_rst_level", level, 2);
    // asynchronous reset mid-operation
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", tvalid, 0);
    tick();
    rst_ni = 1'b1;
    tick();
`ifdef RVFI_TRACE_ORDER_EN
    // order stamps: accept 3, drop 2, accept 1 on a 4-deep buffer
    instr4[0] = '{valid: 1'b1, insn: 32'h700};
    instr4[1] = '{valid: 1'b1, insn: 32'h701};
    tick();
    instr4[0] = '{valid: 1'b1, insn: 32'h702};
    instr4[1] = '0;
    tick();
    instr4[0] = '{valid: 1'b1, insn: 32'h703};
    instr4[1] = '{valid: 1'b1, insn: 32'h704};
    tick();
    instr4[0] = '{valid: 1'b1, insn: 32'h705};
    instr4[1] = '0;
    tick();
    instr4 = '0;
    chk("ord_level", level4, 4);
    chk("ord_drop", drop4, 2);
    chk("ord0", trace4.order, 0);
    ready4 = 1'b1;
    tick();
    chk("ord1", trace4.order, 1);
    tick();
    chk("ord2", trace4.order, 2);
    tick();
    chk("ord5", trace4.order, 5);
    chk("ord5_insn", trace4.rvfi.insn, 'h705);
    ready4 = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
